// File: rtl/anubis_dec_key_buffer.sv
// Decryption key buffer for Anubis. It stores the encryption round keys once
// and replays them in reverse order, passing the middle keys through theta.

module anubis_theta (
  input  logic [127:0] a,
  output logic [127:0] b
);
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
  endfunction

  // Multiply by an entry of the Hadamard row {01,02,04,06}
  function automatic logic [7:0] mul_h(input logic [7:0] x, input logic [1:0] sel);
    logic [7:0] x2;
    logic [7:0] x4;
    x2 = xtime(x);
    x4 = xtime(x2);
    case (sel)
      2'd0:    mul_h = x;
      2'd1:    mul_h = x2;
      2'd2:    mul_h = x4;
      default: mul_h = x4 ^ x2;
    endcase
  endfunction

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      localparam logic [1:0] C = 2'(c);
      assign b[127-8*(4*r+c) -: 8] = mul_h(a[127-8*(4*r+0) -: 8], C ^ 2'd0)
                                   ^ mul_h(a[127-8*(4*r+1) -: 8], C ^ 2'd1)
                                   ^ mul_h(a[127-8*(4*r+2) -: 8], C ^ 2'd2)
                                   ^ mul_h(a[127-8*(4*r+3) -: 8], C ^ 2'd3);
    end
  end
endmodule

module anubis_dec_key_buffer #(
  parameter int ROUNDS = 12,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_key,
  input  logic             wr_valid,
  input  logic [127:0]     wr_key,
  output logic             wr_ready,
  output logic             keys_ready,
  input  logic             rd_start,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [127:0]     rd_key,
  output logic [IDX_W-1:0] rd_idx,
  output logic             rd_last
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS);

  typedef enum logic [1:0] {FILL, LOADED, STREAM} state_t;

  state_t           state;
  state_t           state_next;
  logic [127:0]     mem [0:ROUNDS];
  logic [IDX_W-1:0] wr_cnt;
  logic             mem_we;
  logic             rd_load;
  logic             rd_done;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] sel_addr;
  logic [127:0]     sel_raw;
  logic [127:0]     sel_theta;
  logic [127:0]     sel_key;

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    rd_load    = 1'b0;
    rd_done    = 1'b0;
    sel_idx    = '0;
    if (load_key) begin
      state_next = FILL;
    end else begin
      case (state)
        FILL: begin
          if (wr_valid) begin
            mem_we = 1'b1;
            if (wr_cnt == LAST) state_next = LOADED;
          end
        end
        LOADED: begin
          if (rd_start) begin
            rd_load    = 1'b1;
            state_next = STREAM;
          end
        end
        STREAM: begin
          if (rd_valid && rd_ready) begin
            if (rd_last) begin
              rd_done    = 1'b1;
              state_next = LOADED;
            end else begin
              rd_load = 1'b1;
              sel_idx = rd_idx + 1'b1;
            end
          end
        end
        default: state_next = FILL;
      endcase
    end
  end

  // Decryption index j reads encryption key ROUNDS-j; only the two ends skip theta
  assign sel_addr = LAST - sel_idx;
  assign sel_raw  = mem[sel_addr];

  anubis_theta u_theta (
    .a (sel_raw),
    .b (sel_theta)
  );

  assign sel_key    = (sel_idx == '0 || sel_idx == LAST) ? sel_raw : sel_theta;
  assign wr_ready   = (state == FILL);
  assign keys_ready = (state != FILL);

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  // Key storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[wr_cnt] <= wr_key;
  end

  always_ff @(posedge clk) begin
    if (reset || load_key) begin
      wr_cnt   <= '0;
      rd_valid <= 1'b0;
      rd_key   <= '0;
      rd_idx   <= '0;
      rd_last  <= 1'b0;
    end else begin
      if (mem_we && wr_cnt != LAST) wr_cnt <= wr_cnt + 1'b1;
      if (rd_load) begin
        rd_valid <= 1'b1;
        rd_idx   <= sel_idx;
        rd_key   <= sel_key;
        rd_last  <= (sel_idx == LAST);
      end else if (rd_done) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_anubis_dec_key_buffer.sv
// Bench for anubis_dec_key_buffer: a transaction-level model of the key store
// and a GF(2^8) theta model are compared against the DUT every cycle.

module tb_anubis_dec_key_buffer;
  localparam int ROUNDS = 12;
  localparam int IDX_W  = 4;
  localparam int NK     = ROUNDS + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_key;
  logic             wr_valid;
  logic [127:0]     wr_key;
  logic             wr_ready;
  logic             keys_ready;
  logic             rd_start;
  logic             rd_valid;
  logic             rd_ready;
  logic [127:0]     rd_key;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_last;

  always #5 clk = ~clk;

  anubis_dec_key_buffer #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_key   (load_key),
    .wr_valid   (wr_valid),
    .wr_key     (wr_key),
    .wr_ready   (wr_ready),
    .keys_ready (keys_ready),
    .rd_start   (rd_start),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_key     (rd_key),
    .rd_idx     (rd_idx),
    .rd_last    (rd_last)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [127:0] mk [NK];
  int           m_count = 0;
  int           m_idx = 0;
  bit           m_streaming = 0;
  bit           cmp_en = 0;
  logic [127:0] drain_q [$];
  logic [127:0] ref_q [$];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    int aa;
    int p;
    aa = int'(a);
    p  = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa << 1;
      if ((aa & 'h100) != 0) aa = aa ^ 'h11D;
    end
    return p[7:0];
  endfunction

  // Row-vector times the Hadamard matrix had(01,02,04,06), row by row
  function automatic logic [127:0] theta_m(input logic [127:0] a);
    logic [7:0]   h [4];
    logic [7:0]   acc;
    logic [127:0] res;
    h[0] = 8'h01; h[1] = 8'h02; h[2] = 8'h04; h[3] = 8'h06;
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gf_mul(a[127-8*(4*r+k) -: 8], h[k ^ c]);
        res[127-8*(4*r+c) -: 8] = acc;
      end
    return res;
  endfunction

  function automatic logic [127:0] dec_key(input int j);
    if (j == 0)      return mk[ROUNDS];
    if (j == ROUNDS) return mk[0];
    return theta_m(mk[ROUNDS-j]);
  endfunction

  function automatic logic [127:0] key_for(input int mode, input int i);
    if (mode == 0) return {16{8'(i)}};
    if (mode == 1) return {8'(i), 120'h0102030405060708090A0B0C0D0E0F};
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input bit rst, input bit lk, input bit wv,
                               input logic [127:0] wk, input bit rs, input bit rr);
    reset    = rst;
    load_key = lk;
    wr_valid = wv;
    wr_key   = wk;
    rd_start = rs;
    rd_ready = rr;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: key count, stream flag and current index
  always @(posedge clk) begin
    if (reset || load_key) begin
      m_count     = 0;
      m_streaming = 0;
      m_idx       = 0;
    end else if (m_count < NK) begin
      if (wr_valid) begin
        mk[m_count] = wr_key;
        m_count++;
      end
    end else if (!m_streaming) begin
      if (rd_start) begin
        m_streaming = 1;
        m_idx       = 0;
      end
    end else if (rd_ready) begin
      if (m_idx == ROUNDS) m_streaming = 0;
      else                 m_idx++;
    end
    cmp_en = 1;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("wr_ready", 128'(wr_ready), 128'(m_count < NK));
      checkOutput("keys_ready", 128'(keys_ready), 128'(m_count == NK));
      checkOutput("rd_valid", 128'(rd_valid), 128'(m_streaming));
      checkOutput("rd_last", 128'(rd_last), 128'(m_streaming && m_idx == ROUNDS));
      if (m_streaming) begin
        checkOutput("rd_idx", 128'(rd_idx), 128'(m_idx));
        checkOutput("rd_key", rd_key, dec_key(m_idx));
      end
    end
  end

  task automatic fill(input int mode, input int reset_at);
    int           i;
    int           cycles;
    bit           wv;
    logic [127:0] k;
    i      = 0;
    cycles = 0;
    while (i < NK && cycles < 200) begin
      wv = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      k  = key_for(mode, i);
      if (reset_at >= 0 && i == reset_at) begin
        applyStimulus(1, 0, 1, k, 0, 0);
        return;
      end
      if (mode == 0 && i == NK - 1) checkOutput("keys_ready_before_last", 128'(keys_ready), 128'(0));
      applyStimulus(0, 0, wv, k, 1'($urandom_range(0, 1)), 0);
      if (wv) i++;
      cycles++;
    end
    if (i < NK) checkOutput("fill_timeout", 128'(i), 128'(NK));
  endtask

  task automatic drain(input int mode, input int abort_at, input bit poke);
    int cycles;
    int accepted;
    bit done;
    bit rr;
    bit pat [4];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    drain_q.delete();
    applyStimulus(0, 0, 0, '0, 1, 0);
    checkOutput("start_rd_valid", 128'(rd_valid), 128'(1));
    checkOutput("start_rd_idx", 128'(rd_idx), 128'(0));
    cycles   = 0;
    accepted = 0;
    done     = 0;
    while (!done && cycles < 200) begin
      if (abort_at >= 0 && rd_valid && int'(rd_idx) == abort_at) begin
        applyStimulus(0, 1, 0, '0, 0, 0);
        return;
      end
      if (mode == 0)      rr = 1;
      else if (mode == 1) rr = pat[cycles % 4];
      else                rr = 1'($urandom_range(0, 1));
      if (rd_valid && rr) begin
        accepted++;
        drain_q.push_back(rd_key);
        if (rd_last) done = 1;
      end
      applyStimulus(0, 0, poke && cycles == 3, key_for(2, 0), poke && cycles == 5, rr);
      cycles++;
    end
    if (!done) checkOutput("drain_timeout", 128'(cycles), 128'(0));
    checkOutput("accepted_count", 128'(accepted), 128'(NK));
  endtask

  task automatic check_flushed(input string tag);
    checkOutput({tag, "_rd_valid"}, 128'(rd_valid), 128'(0));
    checkOutput({tag, "_keys_ready"}, 128'(keys_ready), 128'(0));
    checkOutput({tag, "_wr_ready"}, 128'(wr_ready), 128'(1));
  endtask

  initial begin
    int diffs;
    applyStimulus(1, 0, 0, '0, 0, 0);
    applyStimulus(1, 0, 0, '0, 0, 0);
    checkOutput("reset_rd_key", rd_key, 128'h0);
    checkOutput("reset_rd_idx", 128'(rd_idx), 128'(0));
    check_flushed("reset");

    checkOutput("theta_pin_const", theta_m({16{8'h0B}}), {16{8'h0B}});
    checkOutput("theta_pin_unit", theta_m({8'h01, 120'h0}), {32'h01020406, 96'h0});
    checkOutput("theta_pin_reduce", theta_m({8'h80, 120'h0}), {32'h801D3A27, 96'h0});

    $display("[TB] fill and constant-key drain");
    fill(0, -1);
    checkOutput("fill_keys_ready", 128'(keys_ready), 128'(1));
    checkOutput("fill_wr_ready", 128'(wr_ready), 128'(0));
    drain(0, -1, 0);
    checkOutput("const_idx0", drain_q[0], {16{8'h0C}});
    checkOutput("const_idx1", drain_q[1], {16{8'h0B}});
    checkOutput("const_idx12", drain_q[12], 128'h0);

    $display("[TB] non-uniform keys through theta");
    applyStimulus(0, 1, 0, '0, 0, 0);
    fill(1, -1);
    drain(0, -1, 0);
    checkOutput("nonuni_idx0", drain_q[0], {8'h0C, 120'h0102030405060708090A0B0C0D0E0F});
    checkOutput("nonuni_idx12", drain_q[12], {8'h00, 120'h0102030405060708090A0B0C0D0E0F});

    $display("[TB] backpressure and re-drain");
    drain(1, -1, 0);
    ref_q = drain_q;
    applyStimulus(0, 0, 1, key_for(2, 0), 0, 0);
    drain(2, -1, 1);
    diffs = 0;
    for (int i = 0; i < NK; i++)
      if (i >= drain_q.size() || drain_q[i] !== ref_q[i]) diffs++;
    checkOutput("redrain_identical", 128'(diffs), 128'(0));

    $display("[TB] flush mid-stream and reset mid-fill");
    drain(0, 5, 0);
    check_flushed("flush");
    fill(2, -1);
    drain(2, -1, 0);
    applyStimulus(0, 1, 0, '0, 0, 0);
    fill(2, 7);
    check_flushed("midfill_reset");
    fill(2, -1);
    drain(2, -1, 1);

    $display("[TB] randomized rounds");
    for (int n = 0; n < 4; n++) begin
      applyStimulus(0, 1, 1, key_for(2, 0), 0, 0);
      fill(2, -1);
      drain(2, -1, 1'($urandom_range(0, 1)));
      drain(1, -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/anubis_dec_key_buffer.md
Name: anubis_dec_key_buffer

Overview:
- Consumer end of the key schedule. Captures the ROUNDS+1 encryption round keys K^0..K^R produced by key selection, in generation order.
- Replays them to the decryption datapath as decryption round keys, in reverse order:
  - K'^0 = K^R
  - K'^R = K^0
  - K'^r = theta(K^(R-r)) for 0<r<R
- theta is the team's existing combinational 128-bit theta module, instantiated once on the read path.
- The buffer is loaded once per cipher key and drained any number of times, once per decrypted block.

Parameters:
- ROUNDS, 12, number of Anubis rounds R (8+N, N=4 for 128-bit key); ROUNDS+1 keys stored.
- IDX_W, 4, width of key index counters; must satisfy 2^IDX_W > ROUNDS.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- load_key  in  1  new cipher key pending; flushes buffer, returns to FILL.
- wr_valid  in  1  wr_key holds the next encryption round key.
- wr_key  in  128  encryption round key K^i, i = write count.
- wr_ready  out  1  buffer accepting keys (FILL state).
- keys_ready  out  1  all ROUNDS+1 keys stored, buffer drainable.
- rd_start  in  1  begin streaming decryption keys.
- rd_valid  out  1  rd_key valid.
- rd_ready  in  1  consumer accepts rd_key this cycle.
- rd_key  out  128  decryption round key K'^rd_idx.
- rd_idx  out  IDX_W  decryption round index 0..ROUNDS.
- rd_last  out  1  high with rd_valid when rd_idx==ROUNDS.

Behaviour:
- Reset: state=FILL, wr_cnt=0, rd_cnt=0, wr_ready=1, keys_ready=0, rd_valid=0, rd_key=0, rd_idx=0, rd_last=0. Key array contents are not reset; no output may expose them before FILL completes.
- States: FILL, LOADED, STREAM.
- FILL:
  - wr_ready=1.
  - On wr_valid, store wr_key at mem[wr_cnt] and increment wr_cnt.
  - When the write at wr_cnt==ROUNDS occurs, go to LOADED next cycle; keys_ready=1 from that cycle.
  - rd_start is ignored.
- LOADED:
  - wr_ready=0; wr_valid is ignored.
  - On rd_start, rd_cnt=0 and go to STREAM.
- STREAM entry:
  - rd_start sampled at edge t gives rd_valid=1 at t+1, with rd_key=K^ROUNDS and rd_idx=0.
  - rd_key, rd_idx, rd_valid and rd_last are registered outputs.
- Key select for decryption index j:
  - j==0: rd_key = mem[ROUNDS], raw.
  - j==ROUNDS: rd_key = mem[0], raw.
  - otherwise: rd_key = theta(mem[ROUNDS-j]).
- Advance:
  - On rd_valid&&rd_ready with rd_idx<ROUNDS, load index rd_idx+1 next cycle. This gives one key per cycle under continuous rd_ready, with no bubbles.
  - rd_valid&&!rd_ready holds rd_key, rd_idx and rd_valid stable.
- Completion:
  - rd_valid&&rd_ready&&rd_last drops rd_valid and rd_last next cycle and returns to LOADED. keys_ready stays 1.
  - The buffer can be drained again unchanged.
- rd_start while in STREAM is ignored; the stream is not restarted.
- load_key (any state) has priority over all other inputs that cycle:
  - next cycle: state=FILL, wr_cnt=0, keys_ready=0, rd_valid=0, rd_last=0, wr_ready=1.
  - wr_valid coincident with load_key is not stored.
- Reset mid-operation (any state) behaves identically to power-on reset.
- wr_cnt never exceeds ROUNDS; there is no wrap-around of either counter.
- keys_ready is 0 in FILL and 1 in LOADED and STREAM.

Test Plan:
- Fill test:
  - Stimulus: reset, then write 13 keys K^i = 16 bytes of 8'hi (i=0..12), wr_valid every cycle.
  - Required: wr_ready=1 throughout; keys_ready=1 exactly one cycle after the 13th write; wr_ready=0 afterwards.
- Reverse order with constant keys:
  - Stimulus: rd_start, rd_ready=1.
  - Required: rd_valid the cycle after rd_start; 13 consecutive keys with rd_idx=0..12 and rd_key=0x0C0C..0C, 0x0B0B..0B, …, 0x0000..00.
  - theta(constant-byte vector) equals itself since 1^2^4^6=1.
  - rd_last only on rd_idx=12; returns to LOADED.
- theta path with non-uniform keys:
  - Stimulus: K^i = {i, 8'h01..8'h0F}.
  - Required: rd_key at idx 0 = K^12 and at idx 12 = K^0 bit-exact; idx 1..11 match the reference-model theta(K^(12-idx)).
- Backpressure:
  - Stimulus: toggle rd_ready 1,0,0,1 repeatedly during the stream.
  - Required: rd_key and rd_idx hold while rd_ready=0; no key skipped or duplicated; exactly 13 accepted transfers.
- Re-drain and ignored inputs:
  - Stimulus: after a full drain, assert rd_start again; also pulse wr_valid in LOADED and rd_start mid-stream.
  - Required: the identical 13-key sequence; the extra wr_valid and rd_start have no effect.
- Flush and reset:
  - Stimulus: load_key at stream idx 5; separately, reset at FILL write 7.
  - Required: next cycle rd_valid=0, keys_ready=0, wr_ready=1, state FILL. A fresh 13-key fill with new values streams only the new keys.
